// File: rtl/serial_pattern_pkg.sv
// Shared types, default pattern constants and pattern-vector helper for serial_pattern_matcher.
package serial_pattern_pkg;

   typedef enum logic {
      FILLING = 1'b0,
      ARMED   = 1'b1
   } state_t;

   localparam logic [2:0] PAT_ONES3 = 3'b111;
   localparam logic [2:0] PAT_001   = 3'b001;

   // Upper bounds for the generic extraction helper
   localparam int unsigned MAX_W        = 64;
   localparam int unsigned MAX_PAT_BITS = 1024;

   // Returns pattern k (width bits, zero-extended) from a packed pattern vector
   function automatic logic [MAX_W-1:0] pat_extract(input logic [MAX_PAT_BITS-1:0] pats,
                                                    input int unsigned width,
                                                    input int unsigned k);
      logic [MAX_PAT_BITS-1:0] sh;
      logic [MAX_W-1:0]        mask;
      sh   = pats >> (k * width);
      mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
      return MAX_W'(sh) & mask;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment together yield 1.
module sat_counter
   import serial_pattern_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] value
);

   logic [CNT_W-1:0] r_val;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_val <= '0;
      end else if (clr) begin
         r_val <= CNT_W'(inc);
      end else if (inc && (r_val != '1)) begin
         r_val <= r_val + CNT_W'(1);
      end
   end

   assign value = r_val;

endmodule

// File: rtl/serial_pattern_matcher.sv
// Serial bit-stream detector: compares a WIDTH-bit history against NUM_PAT patterns.
module serial_pattern_matcher
   import serial_pattern_pkg::*;
#(
   parameter int unsigned                 WIDTH    = 3,
   parameter int unsigned                 NUM_PAT  = 2,
   parameter logic [NUM_PAT*WIDTH-1:0]    PATTERNS = {PAT_001, PAT_ONES3},
   parameter int unsigned                 CNT_W    = 8
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     in_valid,
   input  logic                     in_bit,
   input  logic                     overlap,
   input  logic                     clear_cnt,
   output logic [NUM_PAT-1:0]       match,
   output logic                     match_any,
   output logic [NUM_PAT*CNT_W-1:0] count
);

   localparam int unsigned FILL_W = $clog2(WIDTH + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
   localparam logic [MAX_PAT_BITS-1:0] PATS_EXT = MAX_PAT_BITS'(PATTERNS);

   state_t              r_state, w_state_nxt;
   logic [WIDTH-1:0]    r_hist, w_hist_nxt, w_shift;
   logic [FILL_W-1:0]   r_fill, w_fill_nxt, w_fill_inc;
   logic [NUM_PAT-1:0]  r_match, w_match_nxt;
   logic                r_match_any;
   logic [WIDTH-1:0]    w_pat [NUM_PAT];

   for (genvar k = 0; k < NUM_PAT; k++) begin : g_pat
      assign w_pat[k] = WIDTH'(pat_extract(PATS_EXT, WIDTH, k));
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state     <= FILLING;
         r_hist      <= '0;
         r_fill      <= '0;
         r_match     <= '0;
         r_match_any <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_hist      <= w_hist_nxt;
         r_fill      <= w_fill_nxt;
         r_match     <= w_match_nxt;
         r_match_any <= |w_match_nxt;
      end
   end

   // Matches only count once the window is full, so reset-zero history is never compared
   always_comb begin
      w_state_nxt = r_state;
      w_hist_nxt  = r_hist;
      w_fill_nxt  = r_fill;
      w_match_nxt = '0;
      w_shift     = {r_hist[WIDTH-2:0], in_bit};
      w_fill_inc  = (r_fill == FILL_FULL) ? r_fill : (r_fill + FILL_W'(1));
      if (in_valid) begin
         if (w_fill_inc == FILL_FULL) begin
            for (int k = 0; k < NUM_PAT; k++) begin
               if (w_shift == w_pat[k]) w_match_nxt[k] = 1'b1;
            end
         end
         w_hist_nxt  = w_shift;
         w_fill_nxt  = w_fill_inc;
         w_state_nxt = (w_fill_inc == FILL_FULL) ? ARMED : FILLING;
         if ((|w_match_nxt) && !overlap) begin
            w_hist_nxt  = '0;
            w_fill_nxt  = '0;
            w_state_nxt = FILLING;
         end
      end
   end

   for (genvar k = 0; k < NUM_PAT; k++) begin : g_cnt
      sat_counter #(.CNT_W(CNT_W)) u_cnt (
         .clock   (clock),
         .reset_n (reset_n),
         .clr     (clear_cnt),
         .inc     (w_match_nxt[k]),
         .value   (count[k*CNT_W +: CNT_W])
      );
   end

   assign match     = r_match;
   assign match_any = r_match_any;

endmodule

// File: tb/tb_serial_pattern_matcher.sv
// Directed self-checking bench for serial_pattern_matcher (default and CNT_W=2 instances).
module tb_serial_pattern_matcher;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_bit;
   logic        overlap;
   logic        clear_cnt;
   logic [1:0]  match, match2;
   logic        match_any, match_any2;
   logic [15:0] count;
   logic [3:0]  count2;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   serial_pattern_matcher dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .overlap   (overlap),
      .clear_cnt (clear_cnt),
      .match     (match),
      .match_any (match_any),
      .count     (count)
   );

   serial_pattern_matcher #(.CNT_W(2)) dut2 (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .overlap   (overlap),
      .clear_cnt (clear_cnt),
      .match     (match2),
      .match_any (match_any2),
      .count     (count2)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge
   task automatic tick(input logic v, input logic b);
      in_valid = v;
      in_bit   = b;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick(1'b0, 1'b0);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_bit    = 1'b0;
      overlap   = 1'b1;
      clear_cnt = 1'b0;

      // Reset state
      do_reset();
      chk("rst_match", 16'(match), 16'h0);
      chk("rst_any", 16'(match_any), 16'h0);
      chk("rst_count", count, 16'h0);

      // 1: three valid ones, overlap
      tick(1'b1, 1'b1); chk("t1_b1", 16'(match), 16'h0);
      tick(1'b1, 1'b1); chk("t1_b2", 16'(match), 16'h0);
      tick(1'b1, 1'b1); chk("t1_b3", 16'(match), 16'h1);
      chk("t1_any", 16'(match_any), 16'h1);
      chk("t1_cnt0", 16'(count[7:0]), 16'h1);
      tick(1'b0, 1'b0); chk("t1_pulse_end", 16'(match), 16'h0);
      chk("t1_any_end", 16'(match_any), 16'h0);

      // 2: six ones, overlap
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         tick(1'b1, 1'b1);
         chk($sformatf("t2_b%0d", i), 16'(match), (i >= 3) ? 16'h1 : 16'h0);
      end
      chk("t2_cnt0", 16'(count[7:0]), 16'h4);
      chk("t2_cnt1", 16'(count[15:8]), 16'h0);

      // 3: six ones, non-overlap (bit 4 gives history 001 but window not full)
      do_reset();
      overlap = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick(1'b1, 1'b1);
         chk($sformatf("t3_b%0d", i), 16'(match), (i == 3 || i == 6) ? 16'h1 : 16'h0);
      end
      chk("t3_cnt0", 16'(count[7:0]), 16'h2);
      chk("t3_cnt1", 16'(count[15:8]), 16'h0);

      // 4: 0,0, three invalid cycles, then 1 -> pattern 1
      do_reset();
      overlap = 1'b1;
      tick(1'b1, 1'b0); chk("t4_b1", 16'(match), 16'h0);
      tick(1'b1, 1'b0); chk("t4_b2", 16'(match), 16'h0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'(i % 2 == 0));
         chk($sformatf("t4_inv%0d", i), 16'(match), 16'h0);
      end
      tick(1'b1, 1'b1); chk("t4_b3", 16'(match), 16'h2);
      chk("t4_any", 16'(match_any), 16'h1);
      chk("t4_cnt1", 16'(count[15:8]), 16'h1);
      tick(1'b0, 1'b0); chk("t4_pulse_end", 16'(match), 16'h0);

      // 5: CNT_W=2 saturation and clear interaction
      do_reset();
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      for (int i = 3; i <= 7; i++) begin
         tick(1'b1, 1'b1);
         chk($sformatf("t5_cnt_b%0d", i), 16'(count2[1:0]), (i >= 5) ? 16'h3 : 16'(i - 2));
      end
      clear_cnt = 1'b1;
      tick(1'b1, 1'b1);
      chk("t5_clr_match", 16'(count2[1:0]), 16'h1);
      chk("t5_clr_match_m", 16'(match2), 16'h1);
      tick(1'b0, 1'b0);
      chk("t5_clr_alone", 16'(count2[1:0]), 16'h0);
      clear_cnt = 1'b0;
      tick(1'b1, 1'b1);
      chk("t5_after_clr", 16'(count2[1:0]), 16'h1);

      // 6: mid-stream reset discards partial history
      do_reset();
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      reset_n = 1'b0;
      tick(1'b1, 1'b1);
      chk("t6_rst_match", 16'(match), 16'h0);
      reset_n = 1'b1;
      tick(1'b1, 1'b1); chk("t6_b1", 16'(match), 16'h0);
      tick(1'b1, 1'b1); chk("t6_b2", 16'(match), 16'h0);
      tick(1'b1, 1'b1); chk("t6_b3", 16'(match), 16'h1);
      chk("t6_cnt0", 16'(count[7:0]), 16'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
